// File: rtl/ram_fix_dp.sv
// Simple dual-port synchronous RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write result and a zeroing sweep after reset or on request.
module ram_fix_dp #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    clr_i,
    output logic                    busy_o
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int NB        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : gen_bad_width
        $error("ram_fix_dp: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : gen_bad_latency
        $error("ram_fix_dp: RD_LATENCY must be 1 or 2");
    end

    typedef enum logic {
        INIT,
        IDLE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                  ramWe;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [DATA_WIDTH-1:0] ramData;
    logic [NB-1:0]         ramBe;

    logic                  rdAccept;
    logic                  wrAccept;
    logic [DATA_WIDTH-1:0] rdWord;

    logic                  valid1_q;
    logic [DATA_WIDTH-1:0] data1_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The sweep leaves INIT on the same edge that zeroes the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o   = (state_q == INIT);
    assign rdAccept = rd_en_i && (state_q == IDLE);
    assign wrAccept = wr_en_i && (state_q == IDLE);

    always_comb begin
        ramWe   = 1'b0;
        ramAddr = wr_addr_i;
        ramData = wr_data_i;
        ramBe   = wr_be_i;
        if (state_q == INIT) begin
            ramWe   = 1'b1;
            ramAddr = cnt_q[ADDR_WIDTH-1:0];
            ramData = '0;
            ramBe   = '1;
        end else begin
            ramWe   = wr_en_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ramWe) begin
            for (int i = 0; i < NB; i++) begin
                if (ramBe[i]) begin
                    mem_q[ramAddr][8*i +: 8] <= ramData[8*i +: 8];
                end
            end
        end
    end

    // In new-data mode a same-address write is merged lane by lane into the read result.
    always_comb begin
        rdWord = mem_q[rd_addr_i];
        if (RDW_MODE == 1 && wrAccept && (wr_addr_i == rd_addr_i)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_i[i]) begin
                    rdWord[8*i +: 8] = wr_data_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid1_q <= 1'b0;
            data1_q  <= '0;
        end else begin
            valid1_q <= rdAccept;
            if (rdAccept) begin
                data1_q <= rdWord;
            end
        end
    end

    if (RD_LATENCY == 2) begin : gen_lat2
        logic                  valid2_q;
        logic [DATA_WIDTH-1:0] data2_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid2_q <= 1'b0;
                data2_q  <= '0;
            end else begin
                valid2_q <= valid1_q;
                if (valid1_q) begin
                    data2_q <= data1_q;
                end
            end
        end

        assign rd_valid_o = valid2_q;
        assign rd_data_o  = data2_q;
    end else begin : gen_lat1
        assign rd_valid_o = valid1_q;
        assign rd_data_o  = data1_q;
    end

endmodule

// File: doc/ram_fix_dp.md
Name: ram_fix_dp

Overview:
Parametrised simple dual-port synchronous RAM. It is the successor to the team's single-port registered-address RAM and adds:
- independent write and read ports
- byte-lane write enables
- configurable read latency (1 or 2)
- selectable read-during-write behaviour
- a hardware clear sequencer that zeroes the array after reset or on request

It serves as the buffering primitive for parser message and field storage.

Parameters:
ADDR_WIDTH, 6, address bits; RAM_DEPTH = 1 << ADDR_WIDTH words.
DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
RD_LATENCY, 1, cycles from accepted rd_en to rd_valid/rd_data; legal values 1 or 2.
RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new data (byte-merged).

Ports:
clk  in  1  single clock, all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
wr_en  in  1  write request.
wr_addr  in  ADDR_WIDTH  write address.
wr_data  in  DATA_WIDTH  write data.
wr_be  in  NB  byte enables; bit i covers wr_data[8i+7:8i].
rd_en  in  1  read request.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data; holds its last value when rd_valid is low.
rd_valid  out  1  one-cycle pulse per accepted read.
clr  in  1  request a full-array zero sweep.
busy  out  1  high while the clear sweep runs; all requests are ignored while high.

Behaviour:
- Reset (rst_n low, asynchronous):
  - busy=1, rd_valid=0, rd_data=0.
  - All read pipeline stages are cleared; the clear counter is set to 0; the FSM is forced to INIT.
  - The array itself is not reset.
- FSM states: INIT, IDLE.
- INIT:
  - Each posedge writes all-zero to ram[cnt] and increments cnt.
  - On the edge that writes address RAM_DEPTH-1, the FSM moves to IDLE and busy falls on that same edge.
  - busy is therefore high for exactly RAM_DEPTH posedges after rst_n rises.
  - clr is ignored in INIT; the sweep is not restarted.
- IDLE:
  - wr_en=1 updates ram[wr_addr] lane i only where wr_be[i]=1; other lanes are unchanged. wr_be=0 leaves the word unchanged.
  - clr=1 moves the FSM to INIT on the next edge with cnt=0; busy rises on that edge.
  - A write presented in the same cycle as clr is performed; it is overwritten by the sweep.
- Read acceptance: a read is accepted when rd_en=1 and the FSM is in IDLE (busy=0). rd_en and wr_en while busy=1 are dropped silently and produce no rd_valid.
- RD_LATENCY=1: array read on the accept edge; rd_data and rd_valid are registered on that edge, i.e. visible in the following cycle.
- RD_LATENCY=2: one further output register stage; rd_valid and rd_data appear one cycle later.
- Reads accepted before clr take effect complete normally with pre-clear data.
- Throughput: one read and one write per cycle, fully pipelined, no stalls.
- Read-during-write, same address, same accept edge:
  - RDW_MODE=0: returns the word as it was before the write.
  - RDW_MODE=1: enabled lanes come from wr_data, the rest from the old word.
- Different addresses are fully independent.
- Read-after-write: a read accepted on any edge after the write edge sees the new data.
- Address and arithmetic:
  - Addresses are used as-is; no wrap logic is needed because widths are exact.
  - cnt is ADDR_WIDTH+1 bits wide so the terminal count is unambiguous.
- Reset mid-sweep or mid-read: all in-flight reads are discarded (rd_valid=0 at once), and the sweep restarts from address 0 after rst_n rises.
- Parameter checks: illegal values (DATA_WIDTH not a multiple of 8, RD_LATENCY not 1 or 2) must fail elaboration.

Test Plan:
- Release rst_n, hold rd_en=1 at addr 5 -> busy=1 for exactly 64 edges, no rd_valid. The first read after busy falls returns 32'h0 with rd_valid one cycle later (RD_LATENCY=1).
- Write 32'hDEADBEEF to addr 3 with wr_be=4'b1111. Then write 32'h11223344 to addr 3 with wr_be=4'b0101. Read addr 3 -> 32'hDE22BE44.
- addr 7 holds 32'hAAAAAAAA. Write 32'h55555555 (wr_be=4'b1100) and read addr 7 on the same edge -> RDW_MODE=0 returns 32'hAAAAAAAA; RDW_MODE=1 returns 32'h5555AAAA.
- RD_LATENCY=2: back-to-back reads of addrs 0,1,2 on three consecutive cycles (contents 1,2,3) -> rd_valid high for three consecutive cycles starting two cycles after the first accept, with data 1,2,3.
- With addr 9=32'h12345678: pulse clr in the same cycle as a read of addr 9 -> read returns 32'h12345678. busy is then high for 64 edges, and a subsequent read of addr 9 returns 0. A wr_en pulse during busy has no effect.
- Assert rst_n low while a read is in flight and 20 addresses into the sweep -> rd_valid=0 immediately. After release, busy is high for a full 64 edges.
